// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared types and defaults for the serial adder controller.
// The optional WAIT timeout is enabled by defining SERIAL_ADD_CTRL_TIMEOUT_EN.
package serial_add_ctrl_pkg;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_WIDTH          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } ctrl_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: requester-side and adder-side signals of the controller.
// The slave modport is the controller's view, master is the environment's view.
interface serial_add_ctrl_if import serial_add_ctrl_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [WIDTH-1:0]            rsp_sum;
  logic                        rsp_err;
  logic                        add_load;
  logic                        add_start;
  logic [WIDTH-1:0]            add_a;
  logic [WIDTH-1:0]            add_b;
  logic [WIDTH-1:0]            add_sum;
  logic                        add_done;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, add_done,
    output req_ready, rsp_valid, rsp_sum, rsp_err,
           add_load, add_start, add_a, add_b
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, add_done,
    input  req_ready, rsp_valid, rsp_sum, rsp_err,
           add_load, add_start, add_a, add_b
  );

endinterface

// File: rtl/serial_add_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant among N_REQ requests. The pointer names the
// index with highest priority and advances past the winner when update_i is set.
module rr_arbiter import serial_add_ctrl_pkg::*; #(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             update_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] scan_idx_s;
  logic             found_s;
  int               pos_s;

  // Scan from the pointer upward with wrap-around; first pending request wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found_s     = 1'b0;
    pos_s       = 0;
    scan_idx_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos_s = int'(ptr_q) + k;
      if (pos_s >= N_REQ) begin
        pos_s = pos_s - N_REQ;
      end else begin
        pos_s = pos_s;
      end
      scan_idx_s = IDX_W'(pos_s);
      if (!found_s && req_i[scan_idx_s]) begin
        found_s              = 1'b1;
        grant_o[scan_idx_s]  = 1'b1;
        grant_idx_o          = scan_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: one past the accepted winner, wrapping at N_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i) begin
      if (grant_idx_o == IDX_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_o + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, cleared to index 0 by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: shares one bit-serial adder among N_REQ requesters.
// Sequence per request: accept (IDLE) -> LOAD -> RUN (WIDTH cycles) -> WAIT
// for add_done -> RESP strobe to the winner. Defining SERIAL_ADD_CTRL_TIMEOUT_EN
// bounds WAIT to TIMEOUT_CYCLES and reports rsp_err on expiry.
module serial_add_ctrl import serial_add_ctrl_pkg::*; #(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus_if
);

  localparam int                IDX_W   = idx_width(N_REQ);
  localparam int                CNT_W   = idx_width(WIDTH);
  localparam logic [N_REQ-1:0] ONE_REQ = N_REQ'(1);

  // Reject degenerate parameter sets at elaboration.
  if (N_REQ < 1 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("serial_add_ctrl: N_REQ, WIDTH and TIMEOUT_CYCLES must be at least 1");
  end

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;

  logic [N_REQ-1:0] grant_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic [N_REQ-1:0] req_ready_s;
  logic             accept_s;
  logic             busy_s;

`ifdef SERIAL_ADD_CTRL_TIMEOUT_EN
  localparam int TW = idx_width(TIMEOUT_CYCLES);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (bus_if.req_valid),
    .update_i    (accept_s),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s)
  );

  // Ready only to the arbiter winner while idle; forced low while reset is held.
  assign req_ready_s = (state_q == ST_IDLE && rst_n) ? grant_s : '0;
  assign accept_s    = |(bus_if.req_valid & req_ready_s);
  assign busy_s      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_WAIT);

  assign bus_if.req_ready = req_ready_s;
  assign bus_if.add_load  = (state_q == ST_LOAD);
  assign bus_if.add_start = (state_q == ST_RUN);
  assign bus_if.add_a     = busy_s ? a_q : '0;
  assign bus_if.add_b     = busy_s ? b_q : '0;
  assign bus_if.rsp_valid = (state_q == ST_RESP) ? (ONE_REQ << gidx_q) : '0;
  assign bus_if.rsp_sum   = (state_q == ST_RESP) ? sum_q : '0;
`ifdef SERIAL_ADD_CTRL_TIMEOUT_EN
  assign bus_if.rsp_err   = (state_q == ST_RESP) && err_q;
`else
  assign bus_if.rsp_err   = 1'b0;
`endif

  // Next-state and datapath capture for the IDLE/LOAD/RUN/WAIT/RESP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    gidx_d  = gidx_q;
`ifdef SERIAL_ADD_CTRL_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = bus_if.req_a[grant_idx_s];
          b_d     = bus_if.req_b[grant_idx_s];
          gidx_d  = grant_idx_s;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
`ifdef SERIAL_ADD_CTRL_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // add_done wins over an expiring timeout in the same cycle.
        if (bus_if.add_done) begin
          sum_d   = bus_if.add_sum;
          state_d = ST_RESP;
`ifdef SERIAL_ADD_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          sum_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-data registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      gidx_q  <= '0;
`ifdef SERIAL_ADD_CTRL_TIMEOUT_EN
      wcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      gidx_q  <= gidx_d;
`ifdef SERIAL_ADD_CTRL_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Shares a single bit-serial adder (load / start / done protocol) among `N_REQ` requesters. A round-robin arbiter picks one pending request and sequences the adder through load and a `WIDTH`-cycle start burst. The controller then waits for `done` and returns the sum to the winning requester. It sits between the requester ports and one `bit_serial_adder` instance.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters
- `WIDTH`, 4, operand/sum width; also the length of the start burst
- `TIMEOUT_CYCLES`, 16, WAIT-state limit (used only with the macro below)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  `N_REQ`  request pending, one bit per requester
- `req_a`, `req_b`  in  `N_REQ`x`WIDTH`  operands per requester
- `req_ready`  out  `N_REQ`  one-hot acceptance
- `rsp_valid`  out  `N_REQ`  one-hot, 1-cycle response strobe
- `rsp_sum`  out  `WIDTH`  result, valid with `rsp_valid`
- `rsp_err`  out  1  timeout flag, valid with `rsp_valid`
- `add_load`, `add_start`  out  1  adder controls
- `add_a`, `add_b`  out  `WIDTH`  adder operands
- `add_sum`  in  `WIDTH`  adder result
- `add_done`  in  1  adder completion

## Operation
- **FSM states:** IDLE, LOAD, RUN, WAIT, RESP.
- **IDLE:**
  - The arbiter drives `req_ready` to the winner only, and only when at least one `req_valid` is high.
  - Acceptance happens on the edge where `req_valid[i] && req_ready[i]`.
  - On acceptance, register `req_a[i]`, `req_b[i]` and the grant index, then go to LOAD.
- **LOAD:** one cycle, `add_load=1`, `add_a`/`add_b` = captured operands. Then go to RUN.
- **RUN:** `add_start=1` for exactly `WIDTH` cycles, counted by a cycle counter. Then go to WAIT.
- **WAIT:**
  - On the first edge with `add_done=1`, capture `add_sum` and go to RESP.
- **RESP:**
  - One cycle, `rsp_valid[grant]=1`, `rsp_sum` = captured sum. Then go to IDLE.
- **Arithmetic:** `rsp_sum` is `(A+B) mod 2^WIDTH`. The controller passes `add_sum` through unmodified.
- **Round-robin:**
  - The pointer starts at 0 after reset.
  - On acceptance of index i, the pointer becomes `(i+1) mod N_REQ`.
  - Among simultaneous requests, the lowest index at or after the pointer, with wrap-around, wins.
- **Requester obligations:** hold `req_valid` and operands stable until accepted. Deasserting before acceptance withdraws the request.
- **Operand stability:** `add_a`/`add_b` hold the captured operands from LOAD through WAIT. They are 0 in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, pointer 0.
  - Reset is asynchronous and is effective mid-operation.
  - An in-flight request is dropped with no response.
- **Latency:** with acceptance at edge k, the sequence is:
  - LOAD in cycle k+1.
  - RUN in cycles k+2 … k+1+`WIDTH`.
  - WAIT from k+2+`WIDTH`.
  - If `add_done` is high in the first WAIT cycle, RESP falls in cycle k+3+`WIDTH`. Minimum latency is `WIDTH`+3 cycles (7 for `WIDTH`=4).
- **Back-to-back throughput:** the next acceptance can occur at the first IDLE cycle after RESP. `req_ready` is low in every non-IDLE state.
- **Ignored inputs:** `add_done` is ignored outside WAIT.

## Configuration
- **Macro:** `SERIAL_ADD_CTRL_TIMEOUT_EN`.
- **Defined:**
  - A WAIT counter counts WAIT cycles.
  - If `TIMEOUT_CYCLES` WAIT cycles elapse without `add_done`, go to RESP with `rsp_err=1` and `rsp_sum=0`.
  - If `add_done` arrives in the cycle the limit is reached, it takes priority and `rsp_err=0`.
- **Undefined:** WAIT waits indefinitely. `rsp_err` is tied to 0 and no counter exists.

## Structure
- **Package `serial_add_ctrl_pkg`:**
  - State enum `ctrl_state_t`.
  - Default `WIDTH` and `N_REQ` constants.
- **Sub-module `rr_arbiter`:**
  - Inputs: request vector, pointer update enable.
  - Output: one-hot grant.
  - Owns the pointer.

## Test plan
- Requester 0 alone, A=13, B=11, `add_done` in the first WAIT cycle -> `rsp_valid[0]` pulses once, `rsp_sum`=8, 7 cycles after acceptance.
- All four requesters valid from reset -> grants in order 0,1,2,3. Each gets its own correct sum (e.g. 3+4=7, 15+1=0, 9+9=2, 0+0=0).
- Requester 2 served, then requesters 1 and 3 valid together -> 3 is granted before 1.
- `add_done` delayed 5 cycles in WAIT -> `rsp_valid` exactly 1 cycle after `add_done` is sampled. `add_a`/`add_b` are stable throughout.
- `add_done` never asserted:
  - With `SERIAL_ADD_CTRL_TIMEOUT_EN` -> `rsp_err=1`, `rsp_sum=0` after 16 WAIT cycles.
  - Without it -> FSM stays in WAIT and `req_ready` stays 0.
- `rst_n` pulsed low during RUN -> all outputs 0 immediately and no response is issued. A new request afterwards completes normally with pointer 0.
